flag_bank_ctrl: RTL
===================

Name: flag_bank_ctrl

Overview:
Sequencer/arbiter that shares one bank of WIDTH JK flip-flops (CPU status flags) between two requesters. Port A is the ALU flag-writeback path and loads a full value. Port B is the microcode path and sets, clears or toggles masked bits. The block latches the granted request, drives the bank's shared j/k buses and generates the bank's clock strobe with setup and hold cycles around it, then acknowledges the requester.

Parameters:
WIDTH, 4, number of flip-flops in the bank (width of j/k buses and data inputs); legal range 1..16

Ports:
clk  input  1  system clock; all state changes on rising edge
_reset  input  1  synchronous reset, active low; sampled on rising edge of clk
a_req  input  1  port A request (ALU load)
a_val  input  WIDTH  port A value to load into the bank
a_ack  output  1  port A done; single-cycle pulse
b_req  input  1  port B request (microcode op)
b_op  input  2  port B op: 00 nop, 01 set, 10 clear, 11 toggle
b_mask  input  WIDTH  port B bit select; 1 = bit affected
b_ack  output  1  port B done; single-cycle pulse
ff_j  output  WIDTH  J bus to the flip-flop bank
ff_k  output  WIDTH  K bus to the flip-flop bank
ff_clk  output  1  bank clock strobe; rising edge updates the flops
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (_reset low at a clk edge): state=IDLE, ff_j=0, ff_k=0, ff_clk=0, a_ack=0, b_ack=0, busy=0, last_grant=B (so A wins the first tie). Reset overrides everything.
- Reset mid-operation: the transaction is abandoned with no ack. ff_clk goes low at the reset edge. If STROBE was already reached, the bank has been updated; no rollback.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE; fixed sequence, no early exit.
- IDLE: ff_clk=0, ff_j=ff_k=0. If any req is high, grant one, latch its data into internal j/k registers, set last_grant, go to SETUP. Otherwise stay.
- Arbitration: only one req high -> grant it. Both high -> grant the port that is not last_grant (round-robin).
- Data mapping, computed at grant:
  - Port A: j = a_val, k = ~a_val (full load).
  - Port B set: j = mask, k = 0.
  - Port B clear: j = 0, k = mask.
  - Port B toggle: j = mask, k = mask.
  - Port B nop: j = k = 0; the full sequence still runs and the strobe is harmless.
  - Unmasked bits always have j = k = 0 (hold).
- SETUP (1 cycle): ff_j/ff_k driven from latched regs, ff_clk=0, busy=1.
- STROBE (1 cycle): ff_clk=1, ff_j/ff_k unchanged; the bank updates on this rising edge.
- HOLD (1 cycle): ff_clk=0, ff_j/ff_k still driven, granted port's ack=1.
- Next IDLE cycle: ff_j/ff_k return to 0 and ack returns to 0.
- Latency: request seen in IDLE at edge N -> ff_clk high in cycle N+2 -> ack high in cycle N+3. Minimum 4 cycles per transaction, including the IDLE arbitration cycle.
- Handshake:
  - The requester holds req until it sees ack.
  - Data is latched at grant; changes to a_val, b_op or b_mask after grant have no effect.
  - Dropping req after grant is a protocol violation; the transaction still completes and acks.
  - A req still high in the IDLE cycle after ack is treated as a new request.
  - A request that loses arbitration is served next, since round-robin gives it priority.
- Requests arriving while busy are not sampled until IDLE; no queueing beyond the req level.
- Acks are mutually exclusive; at most one ff_clk pulse per transaction; ff_clk is never high in two consecutive cycles.

Test Plan:
- Reset: hold _reset=0 for 2 cycles with a_req=b_req=1 -> all outputs 0, no ack, busy=0. Release -> A granted first.
- Port A load (WIDTH=4), a_val=4'b1010 -> SETUP: ff_j=1010, ff_k=0101, ff_clk=0. Next cycle ff_clk=1. Next cycle a_ack=1. A bench-attached flop bank reads q=1010.
- Port B ops on bank q=1010:
  - set, mask=0101 -> j=0101, k=0000, q=1111.
  - toggle, mask=0011 -> j=k=0011, q=1100.
  - clear, mask=1000 -> j=0000, k=1000, q=0100.
- Contention: a_req and b_req held high continuously -> grants alternate A,B,A,B; a_ack and b_ack pulses are 4 cycles apart and never coincident.
- Data stability: change b_mask during SETUP -> j/k reflect the value latched at grant. Drop b_req during STROBE -> b_ack still pulses in HOLD.
- Reset during STROBE -> next cycle ff_clk=0, ff_j=ff_k=0, no ack. Bank holds the already-strobed value; the controller restarts cleanly from IDLE.

Source files
------------

// File: rtl/flag_bank_ctrl.sv
// flag_bank_ctrl
//   Shares one bank of WIDTH JK flip-flops (CPU status flags) between two
//   requesters and sequences each update as IDLE -> SETUP -> STROBE -> HOLD.
//   Port A (ALU writeback) loads a full value; port B (microcode) sets,
//   clears or toggles the bits selected by a mask.
//
// Ports:
//   clk      system clock, rising edge
//   _reset   synchronous reset, active low
//   a_req    port A request; a_val value to load; a_ack done pulse
//   b_req    port B request; b_op 00 nop/01 set/10 clear/11 toggle;
//            b_mask bit select; b_ack done pulse
//   ff_j     J bus to the bank
//   ff_k     K bus to the bank
//   ff_clk   bank clock strobe (rising edge updates the flops)
//   busy     high whenever the sequencer is not in IDLE
module flag_bank_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             a_req,
    input  logic [WIDTH-1:0] a_val,
    output logic             a_ack,
    input  logic             b_req,
    input  logic [1:0]       b_op,
    input  logic [WIDTH-1:0] b_mask,
    output logic             b_ack,
    output logic [WIDTH-1:0] ff_j,
    output logic [WIDTH-1:0] ff_k,
    output logic             ff_clk,
    output logic             busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_TGL = 2'b11;

    logic [1:0]       state;
    logic             last_b;   // last grant went to port B
    logic             gnt_b;    // port owning the transaction in flight
    logic             pick_b;
    logic [WIDTH-1:0] nxt_j;
    logic [WIDTH-1:0] nxt_k;

    // Round-robin: on a tie, the port that did not win last time goes first.
    assign pick_b = b_req & (~a_req | ~last_b);

    // J/K encoding of the winning request; unmasked bits stay at 00 (hold).
    always_comb begin
        nxt_j = '0;
        nxt_k = '0;
        if (!pick_b) begin
            nxt_j = a_val;
            nxt_k = ~a_val;
        end else begin
            case (b_op)
                OP_SET: nxt_j = b_mask;
                OP_CLR: nxt_k = b_mask;
                OP_TGL: begin
                    nxt_j = b_mask;
                    nxt_k = b_mask;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // All bank-facing outputs are registered so ff_clk is a clean,
    // glitch-free strobe. ff_j/ff_k double as the grant-time data latch.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            state  <= IDLE;
            last_b <= 1'b1;
            gnt_b  <= 1'b0;
            ff_j   <= '0;
            ff_k   <= '0;
            ff_clk <= 1'b0;
            a_ack  <= 1'b0;
            b_ack  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ff_clk <= 1'b0;
                    a_ack  <= 1'b0;
                    b_ack  <= 1'b0;
                    if (a_req || b_req) begin
                        ff_j   <= nxt_j;
                        ff_k   <= nxt_k;
                        gnt_b  <= pick_b;
                        last_b <= pick_b;
                        state  <= SETUP;
                    end else begin
                        ff_j <= '0;
                        ff_k <= '0;
                    end
                end
                SETUP: begin
                    ff_clk <= 1'b1;
                    state  <= STROBE;
                end
                STROBE: begin
                    ff_clk <= 1'b0;
                    a_ack  <= ~gnt_b;
                    b_ack  <= gnt_b;
                    state  <= HOLD;
                end
                HOLD: begin
                    ff_j  <= '0;
                    ff_k  <= '0;
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
